// File: rtl/imm_truncate.sv
// imm_truncate: narrows signed 16-bit words to 14-bit immediates behind a
// 2-entry elastic buffer. Every word is range-checked and converted when it
// is accepted, and overflow statistics are kept alongside the buffer.
module imm_truncate #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] out_imm,
  output logic        out_ovf,
  input  logic        clr_stat,
  output logic        ovf_sticky,
  output logic [7:0]  ovf_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               deliver;
  logic signed [13:0] conv_imm;
  logic               conv_ovf;
  logic signed [13:0] tail_imm;
  logic               tail_ovf;

  // A value fits in 14 signed bits when the top three bits agree.
  function automatic logic fits14(input logic signed [15:0] d);
    return (d[15] == d[14]) && (d[14] == d[13]);
  endfunction

  // Narrow to 14 bits: in-range values pass through, out-of-range values
  // either clamp to the signed limits or wrap by dropping the top bits.
  function automatic logic signed [13:0] narrow14(input logic signed [15:0] d);
    logic signed [13:0] r;
    if (fits14(d)) begin
      r = d[13:0];
    end else if (SATURATE) begin
      r = d[15] ? 14'sh2000 : 14'sh1FFF;
    end else begin
      r = d[13:0];
    end
    return r;
  endfunction

  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;
  assign conv_imm = narrow14(in_data);
  assign conv_ovf = !fits14(in_data);

  // Buffer occupancy transitions from the accept/deliver handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !deliver)      state_nxt = TWO;
        else if (deliver && !accept) state_nxt = EMPTY;
      end
      TWO:     if (deliver) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Occupancy and handshake flags are registered from the next state, so
  // out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Head entry drives the outputs directly; it loads a fresh word when the
  // buffer is (or is becoming) empty, or shifts up from the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm <= 14'h0000;
      out_ovf <= 1'b0;
    end else if (accept && ((state == EMPTY) || ((state == ONE) && deliver))) begin
      out_imm <= conv_imm;
      out_ovf <= conv_ovf;
    end else if ((state == TWO) && deliver) begin
      out_imm <= tail_imm;
      out_ovf <= tail_ovf;
    end
  end

  // Tail entry only ever holds the second word while the head is stalled.
  always_ff @(posedge clk) begin
    if (accept && (state == ONE) && !deliver) begin
      tail_imm <= conv_imm;
      tail_ovf <= conv_ovf;
    end
  end

  // Overflow statistics; a clear coinciding with an overflow counts that
  // overflow as the first one after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'h00;
    end else if (clr_stat) begin
      ovf_sticky <= accept && conv_ovf;
      ovf_count  <= (accept && conv_ovf) ? 8'h01 : 8'h00;
    end else if (accept && conv_ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
    end
  end

endmodule

// File: doc/imm_truncate.md
IMM_TRUNCATE -- requirements
Module: imm_truncate

Interface
REQ-001 Parameter SATURATE, default 1: 1 clamps out-of-range values to the 14-bit signed limits; 0 wraps them by dropping bits [15:14].
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port in_valid, input, 1: in_data is presented.
REQ-005 Port in_ready, output, 1: block can accept a word this cycle.
REQ-006 Port in_data, input, 16: signed 16-bit value to narrow.
REQ-007 Port out_valid, output, 1: out_imm and out_ovf are valid.
REQ-008 Port out_ready, input, 1: consumer accepts the output this cycle.
REQ-009 Port out_imm, output, 14: narrowed signed 14-bit immediate.
REQ-010 Port out_ovf, output, 1: this word did not fit in 14 bits.
REQ-011 Port clr_stat, input, 1: synchronous clear of ovf_sticky and ovf_count.
REQ-012 Port ovf_sticky, output, 1: at least one overflow accepted since the last clear.
REQ-013 Port ovf_count, output, 8: count of accepted overflows, saturating.

Function
REQ-014 A word is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-015 The block SHALL buffer words in a 2-entry FIFO, and all outputs SHALL be driven from registers.
REQ-016 The FIFO SHALL use the states EMPTY, ONE and TWO.
  - EMPTY->ONE on accept.
  - ONE->TWO on accept without delivery.
  - ONE->EMPTY on delivery without accept.
  - TWO->ONE on delivery.
  - All other cases hold the current state.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO; no combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL be 1 in ONE and TWO.
REQ-019 Latency from accept to out_valid in EMPTY SHALL be 1 cycle; sustained throughput SHALL be 1 word per cycle with out_ready held high.
REQ-020 Simultaneous accept and delivery in ONE SHALL stay in ONE, with the new word at the head on the next cycle.
REQ-021 Word order SHALL be preserved; no word is dropped or duplicated.
REQ-022 A word fits iff in_data[15], in_data[14] and in_data[13] are all equal; fitting words SHALL produce out_imm = in_data[13:0] and out_ovf = 0.
REQ-023 For a non-fitting word, out_ovf SHALL be 1.
  - SATURATE=1: out_imm = 14'h1FFF if in_data[15]=0, else 14'h2000.
  - SATURATE=0: out_imm = in_data[13:0].
REQ-024 Range check and conversion SHALL be computed at accept time and stored with the word.
REQ-025 ovf_sticky SHALL set on the cycle after an accepted overflow word.
REQ-026 ovf_count SHALL increment by 1 per accepted overflow word and hold at 255.
REQ-027 clr_stat SHALL clear ovf_sticky and ovf_count on the next edge.
REQ-028 If clr_stat coincides with an accepted overflow, the result SHALL be ovf_sticky = 1 and ovf_count = 1.
REQ-029 Output registers SHALL hold their value while out_valid && !out_ready.

Reset
REQ-030 While rst_n = 0, the outputs SHALL be:
  - state EMPTY, out_valid = 0, in_ready = 0
  - out_imm = 14'h0000, out_ovf = 0
  - ovf_sticky = 0, ovf_count = 8'h00
REQ-031 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words immediately, with no delivery.

Verification
REQ-033 In-range values, out_ready = 1:
  - 0x0FFF -> out_imm 0x0FFF, ovf 0, out_valid one cycle after accept.
  - 0xE000 -> out_imm 0x2000, ovf 0.
  - 0x1FFF -> out_imm 0x1FFF, ovf 0.
REQ-034 SATURATE=1:
  - 0x2000 -> 0x1FFF, ovf 1.
  - 0x8000 -> 0x2000, ovf 1.
  - Then ovf_sticky = 1 and ovf_count = 2.
REQ-035 SATURATE=0:
  - 0x4005 -> 0x0005, ovf 1.
  - 0xC000 -> 0x0000, ovf 1.
REQ-036 Backpressure, out_ready = 0, push A, B, C:
  - in_ready drops after B; C is held off.
  - Raising out_ready delivers A, B, C in order.
  - Throughput is 1 per cycle thereafter.
REQ-037 Statistics:
  - 300 overflow words -> ovf_count = 255.
  - clr_stat together with an overflow accept -> ovf_count = 1, ovf_sticky = 1.
  - clr_stat alone -> ovf_count = 0, ovf_sticky = 0.
REQ-038 Reset mid-operation:
  - rst_n pulsed low while in TWO -> out_valid = 0 immediately and no stale words afterwards.
  - First word after reset emerges correctly.
